rom_frame_painter: RTL and testbench
====================================

Name: rom_frame_painter

Overview:
- Full-screen image blitter between the image-select FSM and vga_adapter (320x240, 9-bit colour).
- On a start pulse it latches one of four ROM images and sweeps the ROM address linearly.
- It compensates for ROM read latency and drives x/y/colour/plot into vga_adapter, one pixel per clock.
- It replaces the ad-hoc counters in the display top level and adds a clean busy/done handshake.

Parameters:
- WIDTH, 320, pixels per row
- HEIGHT, 240, rows per frame
- ROM_LATENCY, 2, clocks from rom_addr change to matching rom_qN valid (range 1..4)
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to paint a frame
- img_sel  input  2  image select, sampled with start: 0=top_left, 1=top_right, 2=bottom_right, 3=game_over
- abort  input  1  synchronous cancel of an in-progress frame
- rom_q0  input  9  colour data from ROM 0
- rom_q1  input  9  colour data from ROM 1
- rom_q2  input  9  colour data from ROM 2
- rom_q3  input  9  colour data from ROM 3
- rom_addr  output  ADDR_W  shared address to all four ROMs (registered)
- x  output  9  pixel column to vga_adapter
- y  output  8  pixel row to vga_adapter
- colour  output  9  pixel colour to vga_adapter
- plot  output  1  write enable to vga_adapter
- busy  output  1  high while a frame is issuing or flushing
- done  output  1  one-cycle pulse after the last pixel of a frame is plotted

Behaviour:
- Reset: all outputs 0; state IDLE; delay pipe valid bits cleared; latched select = 0.
- States:
  - IDLE: busy=0. On start=1, latch img_sel and go to ISSUE. In the cycle after start, rom_addr=0 and busy=1.
  - ISSUE: each cycle rom_addr increments by 1 and issue column/row counters advance (col wraps WIDTH-1 -> 0 with row+1). After issuing address WIDTH*HEIGHT-1, go to FLUSH.
  - FLUSH: no new issues; wait until the delay pipe is empty, then go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE. A start seen in DONE is accepted exactly as in IDLE.
- Delay pipe:
  - Depth ROM_LATENCY; carries {valid, col, row} alongside each issued address.
  - At the pipe output: plot=valid, x=col, y=row, colour=rom_q[latched sel].
  - Outputs are registered so that colour corresponds to the ROM word for the address with the same x/y.
- Latency: start in cycle 0 -> rom_addr=0 in cycle 1 -> first plot in cycle 1+ROM_LATENCY -> last plot in cycle N+ROM_LATENCY, where N=WIDTH*HEIGHT -> done in cycle N+ROM_LATENCY+1.
- Throughput: one pixel per clock, no gaps.
- Row-major order; x = addr mod WIDTH, y = addr div WIDTH. No multiplier or divider: counters only.
- start while busy=1: ignored; img_sel changes while busy do not affect the frame in progress.
- abort while busy=1:
  - Next cycle: state IDLE, pipe valid bits cleared, plot=0, busy=0, no done pulse.
  - rom_addr holds its last value.
- abort and start in the same IDLE cycle: abort wins, frame not started.
- abort in IDLE/DONE: no effect, and the DONE pulse still completes.
- When plot=0, x/y/colour hold their last values.
- rom_addr never exceeds N-1.
- reset_n asserted mid-frame: immediate return to reset values; no partial done.

Test Plan:
- WIDTH=4, HEIGHT=3, ROM_LATENCY=2, ROM model returns colour=addr+{sel,7'b0}; start with img_sel=1 at cycle 0 -> rom_addr=0 at cycle 1; plot high cycles 3..14 with (x,y) (0,0),(1,0)...(3,2), colour=addr+128 each; done=1 only at cycle 15; busy high cycles 1..14.
- Same config, start asserted again at cycles 5 and 10 with img_sel=2 -> ignored, colours remain sel 1, exactly 12 plots, single done.
- Start in the DONE cycle with img_sel=3 -> second frame begins next cycle, colour=addr+384, 12 more plots, second done pulse.
- abort at cycle 7 -> plot=0 from cycle 8, busy=0, no done; a following start paints a full 12-pixel frame beginning at (0,0).
- reset_n low at cycle 6 for 2 cycles -> all outputs 0 immediately; no plot/done until a new start.
- Default parameters (320x240, latency 2), img_sel=0 -> 76800 plots, last at (319,239) with rom_addr 76799; done at cycle 76803 after start; rom_addr never exceeds 76799.

Source files
------------

// File: rtl/rom_frame_painter.sv
// Full-screen ROM-to-VGA blitter: sweeps one of four image ROMs in row-major order and
// plots one pixel per clock, delaying x/y/plot to line up with the ROM read latency.
module rom_frame_painter #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int ROM_LATENCY = 2,
    parameter int ADDR_W      = 17
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        img_sel,
    input  logic              abort,
    input  logic [8:0]        rom_q0,
    input  logic [8:0]        rom_q1,
    input  logic [8:0]        rom_q2,
    input  logic [8:0]        rom_q3,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic [8:0]        colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int                N         = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [8:0]        LAST_COL  = 9'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

    state_t state, next_state;

    logic [1:0]             sel;
    logic [8:0]             issue_col;
    logic [7:0]             issue_row;
    logic [ROM_LATENCY-1:0] pipe_valid;
    logic [8:0]             pipe_col [ROM_LATENCY];
    logic [7:0]             pipe_row [ROM_LATENCY];
    logic [8:0]             rom_word;
    logic [8:0]             colour_hold;
    logic                   accept;
    logic                   issuing;
    logic                   cancel;
    logic                   pipe_draining;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // The final stage of the pipe is the plot register itself, so DONE is entered
    // once only that stage may still hold a pixel; done then follows the last plot.
    always_comb begin
        pipe_draining = 1'b0;
        for (int k = 0; k < ROM_LATENCY - 1; k++) pipe_draining = pipe_draining | pipe_valid[k];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = (start && !abort) ? ISSUE : IDLE;
            ISSUE: begin
                if (abort)                      next_state = IDLE;
                else if (rom_addr == LAST_ADDR) next_state = FLUSH;
            end
            FLUSH: begin
                if (abort)              next_state = IDLE;
                else if (!pipe_draining) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ISSUE) || (state == FLUSH);
        done    = (state == DONE);
        accept  = (state == IDLE || state == DONE) && start && !abort;
        issuing = (state == ISSUE) && !abort;
        cancel  = busy && abort;
    end

    // rom_addr stays put on abort and after the last address, so it never passes N-1.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            issue_col <= '0;
            issue_row <= '0;
            sel       <= '0;
        end else if (accept) begin
            rom_addr  <= '0;
            issue_col <= '0;
            issue_row <= '0;
            sel       <= img_sel;
        end else if (issuing && rom_addr != LAST_ADDR) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            if (issue_col == LAST_COL) begin
                issue_col <= '0;
                issue_row <= issue_row + 8'd1;
            end else begin
                issue_col <= issue_col + 9'd1;
            end
        end
    end

    // Coordinates only advance with a valid token, so x/y hold while plot is low.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                pipe_col[k] <= '0;
                pipe_row[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= issuing;
            if (issuing) begin
                pipe_col[0] <= issue_col;
                pipe_row[0] <= issue_row;
            end
            for (int k = 1; k < ROM_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1] && !cancel;
                if (pipe_valid[k-1] && !cancel) begin
                    pipe_col[k] <= pipe_col[k-1];
                    pipe_row[k] <= pipe_row[k-1];
                end
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    rom_word = rom_q0;
            2'd1:    rom_word = rom_q1;
            2'd2:    rom_word = rom_q2;
            default: rom_word = rom_q3;
        endcase
    end

    // The ROM word arrives from the ROM's own output register in the plot cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)  colour_hold <= '0;
        else if (plot) colour_hold <= rom_word;
    end

    assign plot   = pipe_valid[ROM_LATENCY-1];
    assign x      = pipe_col[ROM_LATENCY-1];
    assign y      = pipe_row[ROM_LATENCY-1];
    assign colour = plot ? rom_word : colour_hold;

endmodule

// File: tb/tb_rom_frame_painter.sv
// Directed bench for rom_frame_painter: a 4x3 instance for handshake/abort/reset cases
// and a default 320x240 instance for one full frame.
module tb_rom_frame_painter;

    localparam int NONE = 1000;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic       reset_n;
    logic       abort;
    logic       start_s;
    logic       start_b;
    logic [1:0] img_sel;

    logic [3:0] s_rom_addr, s_d1, s_d2;
    logic [8:0] s_q0, s_q1, s_q2, s_q3;
    logic [8:0] s_x, s_colour;
    logic [7:0] s_y;
    logic       s_plot, s_busy, s_done;

    logic [16:0] b_rom_addr, b_d1, b_d2;
    logic [8:0]  b_q0, b_q1, b_q2, b_q3;
    logic [8:0]  b_x, b_colour;
    logic [7:0]  b_y;
    logic        b_plot, b_busy, b_done;

    int nChecks = 0;
    int nBad    = 0;
    int mdlX    = 0;
    int mdlY    = 0;
    int mdlColour = 0;

    rom_frame_painter #(.WIDTH(4), .HEIGHT(3), .ROM_LATENCY(2), .ADDR_W(4)) dutSmall (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_s), .img_sel(img_sel), .abort(abort),
        .rom_q0(s_q0), .rom_q1(s_q1), .rom_q2(s_q2), .rom_q3(s_q3),
        .rom_addr(s_rom_addr), .x(s_x), .y(s_y), .colour(s_colour),
        .plot(s_plot), .busy(s_busy), .done(s_done)
    );

    rom_frame_painter dutBig (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_b), .img_sel(img_sel), .abort(abort),
        .rom_q0(b_q0), .rom_q1(b_q1), .rom_q2(b_q2), .rom_q3(b_q3),
        .rom_addr(b_rom_addr), .x(b_x), .y(b_y), .colour(b_colour),
        .plot(b_plot), .busy(b_busy), .done(b_done)
    );

    // Two-clock ROMs: word = addr + 128*rom_index, truncated to 9 bits.
    always @(posedge CLOCK_50) begin
        s_d1 <= s_rom_addr;
        s_d2 <= s_d1;
        b_d1 <= b_rom_addr;
        b_d2 <= b_d1;
    end

    assign s_q0 = 9'(s_d2);
    assign s_q1 = 9'(s_d2) + 9'd128;
    assign s_q2 = 9'(s_d2) + 9'd256;
    assign s_q3 = 9'(s_d2) + 9'd384;
    assign b_q0 = b_d2[8:0];
    assign b_q1 = b_d2[8:0] + 9'd128;
    assign b_q2 = b_d2[8:0] + 9'd256;
    assign b_q3 = b_d2[8:0] + 9'd384;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed != expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Starts a 4x3 frame with image sel, then checks every output for lastCycle cycles.
    // restartAt: cycle of a second start (sel2); abortAt/resetAt: cycle the pulse is driven.
    task automatic applyStimulus(input int sel, input int sel2, input int restartAt,
                                 input int abortAt, input int resetAt, input int lastCycle,
                                 input bit noisy);
        int  r, s, idx, expAddr;
        bit  inReset, alive, expPlot, expBusy, expDone;
        start_s = 1'b1;
        img_sel = 2'(sel);
        @(posedge CLOCK_50); #1;
        for (int c = 1; c <= lastCycle; c++) begin
            start_s = 1'b0;
            abort   = (c == abortAt);
            reset_n = !(c >= resetAt && c < resetAt + 2);
            if (c == restartAt) begin
                start_s = 1'b1;
                img_sel = 2'(sel2);
            end else if (noisy && (c == 5 || c == 10 || c == 20 || c == 25)) begin
                start_s = 1'b1;
                img_sel = 2'd2;
            end
            @(negedge CLOCK_50);
            if (restartAt > 0 && c > restartAt) begin
                r = c - restartAt;
                s = sel2;
            end else begin
                r = c;
                s = sel;
            end
            inReset = (c >= resetAt);
            alive   = (c <= abortAt) && !inReset;
            expPlot = alive && r >= 3 && r <= 14;
            expBusy = alive && r >= 1 && r <= 14;
            expDone = alive && r == 15;
            expAddr = ((r < abortAt) ? r : abortAt) - 1;
            if (expAddr > 11) expAddr = 11;
            if (inReset) expAddr = 0;
            if (expPlot) begin
                idx       = r - 3;
                mdlX      = idx % 4;
                mdlY      = idx / 4;
                mdlColour = (idx + s * 128) % 512;
            end
            if (inReset) begin
                mdlX = 0;
                mdlY = 0;
                mdlColour = 0;
            end
            checkOutput($sformatf("plot c%0d", c), int'(s_plot), int'(expPlot));
            checkOutput($sformatf("busy c%0d", c), int'(s_busy), int'(expBusy));
            checkOutput($sformatf("done c%0d", c), int'(s_done), int'(expDone));
            checkOutput($sformatf("x c%0d", c), int'(s_x), mdlX);
            checkOutput($sformatf("y c%0d", c), int'(s_y), mdlY);
            checkOutput($sformatf("colour c%0d", c), int'(s_colour), mdlColour);
            checkOutput($sformatf("rom_addr c%0d", c), int'(s_rom_addr), expAddr);
            @(posedge CLOCK_50); #1;
        end
        abort   = 1'b0;
        reset_n = 1'b1;
        start_s = 1'b0;
    endtask

    initial begin
        int plotCount, doneCount, doneCycle, firstPlot, lastX, lastY, lastAddr, maxAddr, pixErr;

        reset_n = 1'b0;
        abort   = 1'b0;
        start_s = 1'b0;
        start_b = 1'b0;
        img_sel = 2'd0;
        #12;
        @(negedge CLOCK_50);
        checkOutput("reset plot", int'(s_plot), 0);
        checkOutput("reset busy", int'(s_busy), 0);
        checkOutput("reset done", int'(s_done), 0);
        checkOutput("reset x", int'(s_x), 0);
        checkOutput("reset y", int'(s_y), 0);
        checkOutput("reset colour", int'(s_colour), 0);
        checkOutput("reset rom_addr", int'(s_rom_addr), 0);
        checkOutput("reset big plot", int'(b_plot), 0);
        checkOutput("reset big rom_addr", int'(b_rom_addr), 0);
        @(posedge CLOCK_50); #1;
        reset_n = 1'b1;
        @(posedge CLOCK_50); #1;

        // sel 1 frame with ignored starts, restarted with sel 3 in its DONE cycle
        applyStimulus(1, 3, 15, NONE, NONE, 30, 1'b1);
        // abort mid-frame, then a full clean frame
        applyStimulus(1, 0, 0, 7, NONE, 12, 1'b0);
        applyStimulus(2, 0, 0, NONE, NONE, 16, 1'b0);

        // abort together with start while idle: no frame
        start_s = 1'b1;
        abort   = 1'b1;
        img_sel = 2'd1;
        @(posedge CLOCK_50); #1;
        start_s = 1'b0;
        abort   = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("abort+start busy", int'(s_busy), 0);
        checkOutput("abort+start rom_addr", int'(s_rom_addr), 11);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checkOutput("abort+start busy2", int'(s_busy), 0);
        checkOutput("abort+start plot2", int'(s_plot), 0);
        @(posedge CLOCK_50); #1;

        // reset mid-frame, then a sel 3 frame with abort during DONE
        applyStimulus(0, 0, 0, NONE, 6, 12, 1'b0);
        applyStimulus(3, 0, 0, 15, NONE, 17, 1'b0);

        // full-size frame
        plotCount = 0; doneCount = 0; doneCycle = -1; firstPlot = -1;
        lastX = -1; lastY = -1; lastAddr = -1; maxAddr = 0; pixErr = 0;
        start_b = 1'b1;
        img_sel = 2'd0;
        @(posedge CLOCK_50); #1;
        start_b = 1'b0;
        for (int c = 1; c <= 76810; c++) begin
            @(negedge CLOCK_50);
            if (int'(b_rom_addr) > maxAddr) maxAddr = int'(b_rom_addr);
            if (b_plot) begin
                if (firstPlot < 0) firstPlot = c;
                if (int'(b_x) != plotCount % 320 || int'(b_y) != plotCount / 320 ||
                    int'(b_colour) != plotCount % 512) pixErr++;
                plotCount++;
                lastX = int'(b_x);
                lastY = int'(b_y);
                lastAddr = int'(b_rom_addr);
            end
            if (b_done) begin
                doneCount++;
                doneCycle = c;
            end
        end
        checkOutput("big plots", plotCount, 76800);
        checkOutput("big first plot cycle", firstPlot, 3);
        checkOutput("big pixel errors", pixErr, 0);
        checkOutput("big last x", lastX, 319);
        checkOutput("big last y", lastY, 239);
        checkOutput("big last rom_addr", lastAddr, 76799);
        checkOutput("big max rom_addr", maxAddr, 76799);
        checkOutput("big done count", doneCount, 1);
        checkOutput("big done cycle", doneCycle, 76803);
        checkOutput("big busy after", int'(b_busy), 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
